// File: rtl/note_event_sequencer_pkg.sv
// Shared definitions for the note-event sequencer: default sizes, event word
// field offsets ({time, key, press}) and the sequencer state encoding.
package note_event_sequencer_pkg;

    localparam int NUM_KEYS_DEF = 32;
    localparam int KEY_W_DEF    = 5;
    localparam int TIME_W_DEF   = 20;
    localparam int ADDR_W_DEF   = 10;
    localparam int EV_W_DEF     = TIME_W_DEF + KEY_W_DEF + 1;

    // Event word layout, LSB first: press flag, key index, then timestamp.
    localparam int PRESS_BIT = 0;
    localparam int KEY_LSB   = 1;

    function automatic int time_lsb(input int key_w);
        return KEY_LSB + key_w;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REC      = 3'd1,
        ST_PL_FETCH = 3'd2,
        ST_PL_WAIT  = 3'd3,
        ST_PL_APPLY = 3'd4,
        ST_PL_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/note_event_sequencer_if.sv
// Single-port event RAM bus; master drives address/write, slave returns read
// data one cycle after the address.
interface note_event_sequencer_if
    import note_event_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int EV_W   = EV_W_DEF
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [EV_W-1:0]   mem_wdata;
    logic [EV_W-1:0]   mem_rdata;

    modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);

endinterface

// File: rtl/note_event_sequencer_lowest_set_bit_enc.sv
// Priority encoder: index of the lowest set bit of vec_i, vld_o when any bit
// is set. Purely combinational.
module lowest_set_bit_enc #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         vld_o
);

    // Scan downwards so the lowest set bit is the last one to win.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = W'(i);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_event_sequencer.sv
// Records key-state changes as timestamped events into the event RAM and
// replays them against the shared timer; one event per cycle when recording,
// at least 3 cycles per event when playing back. No backpressure.
module note_event_sequencer
    import note_event_sequencer_pkg::*;
#(
    parameter int NUM_KEYS = NUM_KEYS_DEF,
    parameter int KEY_W    = KEY_W_DEF,
    parameter int TIME_W   = TIME_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int EV_W     = TIME_W + KEY_W + 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                record_mode_i,
    input  logic                playback_mode_i,
    input  logic                restart_pulse_i,
    input  logic [TIME_W-1:0]   timer_count_i,
    input  logic [NUM_KEYS-1:0] key_state_i,
    note_event_sequencer_if.master mem,
    output logic [NUM_KEYS-1:0] play_keys_o,
    output logic [ADDR_W:0]     event_count_o,
    output logic                overflow_o,
    output logic                playback_done_o
);

    localparam int TIME_LSB = time_lsb(KEY_W);
    localparam logic [KEY_W:0]  KEY_LIMIT = (KEY_W + 1)'(NUM_KEYS);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);

    state_t              state_q;
    logic [NUM_KEYS-1:0] rec_keys_q;
    logic [NUM_KEYS-1:0] play_keys_q;
    logic [ADDR_W:0]     event_count_q;
    logic [ADDR_W:0]     rd_ptr_q;
    logic [EV_W-1:0]     ev_q;
    logic                overflow_q;
    logic                done_q;

    logic [NUM_KEYS-1:0] scan_diff;
    logic [KEY_W-1:0]    scan_idx;
    logic                scan_vld;
    logic                full;
    logic                start_pl;
    logic [ADDR_W:0]     event_count_d;
    logic [ADDR_W:0]     rd_ptr_d;

    logic [TIME_W-1:0]   ev_time;
    logic [KEY_W-1:0]    ev_key;
    logic                ev_press;

    assign scan_diff     = key_state_i ^ rec_keys_q;
    assign full          = event_count_q[ADDR_W];
    assign event_count_d = event_count_q + PTR_ONE;
    assign rd_ptr_d      = rd_ptr_q + PTR_ONE;

    assign ev_time  = ev_q[TIME_LSB +: TIME_W];
    assign ev_key   = ev_q[KEY_LSB +: KEY_W];
    assign ev_press = ev_q[PRESS_BIT];

    // Playback (re)starts on restart from anything but REC, or on playback
    // entry from IDLE/REC; PL_DONE holds until the mode changes.
    assign start_pl = (restart_pulse_i && (state_q != ST_REC))
                   || (playback_mode_i && ((state_q == ST_IDLE) || (state_q == ST_REC)));

    lowest_set_bit_enc #(
        .N (NUM_KEYS),
        .W (KEY_W)
    ) u_scan (
        .vec_i (scan_diff),
        .idx_o (scan_idx),
        .vld_o (scan_vld)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            rec_keys_q    <= '0;
            play_keys_q   <= '0;
            event_count_q <= '0;
            rd_ptr_q      <= '0;
            ev_q          <= '0;
            overflow_q    <= 1'b0;
            done_q        <= 1'b0;
        end else if (record_mode_i) begin
            if (state_q != ST_REC) begin
                state_q       <= ST_REC;
                event_count_q <= '0;
                rec_keys_q    <= '0;
                overflow_q    <= 1'b0;
                done_q        <= 1'b0;
                play_keys_q   <= '0;
            end else if (scan_vld) begin
                rec_keys_q[scan_idx] <= ~rec_keys_q[scan_idx];
                if (full) begin
                    overflow_q <= 1'b1;
                end else begin
                    event_count_q <= event_count_d;
                end
            end
        end else if (start_pl) begin
            state_q     <= ST_PL_FETCH;
            rd_ptr_q    <= '0;
            play_keys_q <= '0;
            done_q      <= 1'b0;
        end else if (!playback_mode_i) begin
            state_q     <= ST_IDLE;
            play_keys_q <= '0;
        end else begin
            case (state_q)
                ST_PL_FETCH: begin
                    if (rd_ptr_q == event_count_q) begin
                        state_q     <= ST_PL_DONE;
                        done_q      <= 1'b1;
                        play_keys_q <= '0;
                    end else begin
                        state_q <= ST_PL_WAIT;
                    end
                end
                ST_PL_WAIT: begin
                    ev_q    <= mem.mem_rdata;
                    state_q <= ST_PL_APPLY;
                end
                ST_PL_APPLY: begin
                    if (timer_count_i >= ev_time) begin
                        if ({1'b0, ev_key} < KEY_LIMIT) begin
                            play_keys_q[ev_key] <= ev_press;
                        end
                        rd_ptr_q <= rd_ptr_d;
                        state_q  <= ST_PL_FETCH;
                    end
                end
                ST_PL_DONE: begin
                    play_keys_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM port: write only while actually recording, read address in FETCH.
    always_comb begin
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if ((state_q == ST_REC) && record_mode_i && scan_vld && !full) begin
            mem.mem_we    = 1'b1;
            mem.mem_addr  = event_count_q[ADDR_W-1:0];
            mem.mem_wdata = {timer_count_i, scan_idx, key_state_i[scan_idx]};
        end else if (state_q == ST_PL_FETCH) begin
            mem.mem_addr = rd_ptr_q[ADDR_W-1:0];
        end
    end

    assign play_keys_o     = play_keys_q;
    assign event_count_o   = event_count_q;
    assign overflow_o      = overflow_q;
    assign playback_done_o = done_q;

endmodule

// File: tb/tb_note_event_sequencer.sv
// Directed bench for note_event_sequencer: a 1024-entry instance for record and
// playback, and a 4-entry instance for the overflow case.
module tb_note_event_sequencer;

    localparam int NK  = 32;
    localparam int KW  = 5;
    localparam int TW  = 20;
    localparam int AW  = 10;
    localparam int AWS = 2;
    localparam int EW  = TW + KW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic [TW-1:0] timer;
    logic [NK-1:0] keys;

    logic          rec_a, pb_a, rst_a;
    logic [NK-1:0] play_a;
    logic [AW:0]   cnt_a;
    logic          ovf_a, done_a;

    logic          rec_b, pb_b, rst_b;
    logic [NK-1:0] play_b;
    logic [AWS:0]  cnt_b;
    logic          ovf_b, done_b;

    note_event_sequencer_if #(.ADDR_W(AW),  .EV_W(EW)) mem_a ();
    note_event_sequencer_if #(.ADDR_W(AWS), .EV_W(EW)) mem_b ();

    note_event_sequencer #(.NUM_KEYS(NK), .KEY_W(KW), .TIME_W(TW), .ADDR_W(AW)) dut_a (
        .clk (clk), .resetn (resetn),
        .record_mode_i (rec_a), .playback_mode_i (pb_a), .restart_pulse_i (rst_a),
        .timer_count_i (timer), .key_state_i (keys), .mem (mem_a),
        .play_keys_o (play_a), .event_count_o (cnt_a),
        .overflow_o (ovf_a), .playback_done_o (done_a)
    );

    note_event_sequencer #(.NUM_KEYS(NK), .KEY_W(KW), .TIME_W(TW), .ADDR_W(AWS)) dut_b (
        .clk (clk), .resetn (resetn),
        .record_mode_i (rec_b), .playback_mode_i (pb_b), .restart_pulse_i (rst_b),
        .timer_count_i (timer), .key_state_i (keys), .mem (mem_b),
        .play_keys_o (play_b), .event_count_o (cnt_b),
        .overflow_o (ovf_b), .playback_done_o (done_b)
    );

    logic [EW-1:0] ram_a [0:(1<<AW)-1];
    logic [EW-1:0] ram_b [0:(1<<AWS)-1];

    always @(posedge clk) begin
        if (mem_a.mem_we === 1'b1) ram_a[mem_a.mem_addr] <= mem_a.mem_wdata;
        mem_a.mem_rdata <= ram_a[mem_a.mem_addr];
        if (mem_b.mem_we === 1'b1) ram_b[mem_b.mem_addr] <= mem_b.mem_wdata;
        mem_b.mem_rdata <= ram_b[mem_b.mem_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    // Expected RAM writes as {addr[9:0], event word}.
    logic [AW+EW-1:0] q_a[$];
    logic [AW+EW-1:0] q_b[$];
    logic [AW+EW-1:0] exp_w;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW+EW-1:0] wr(input int addr, input int t, input int k, input bit p);
        return {addr[AW-1:0], t[TW-1:0], k[KW-1:0], p};
    endfunction

    task automatic check_writes();
        if (resetn === 1'b1 && mem_a.mem_we === 1'b1) begin
            n_vec++;
            assert (q_a.size() != 0)
            else begin
                n_err++;
                $error("FAIL wr_a_unexpected observed=%0h expected=no write",
                       {mem_a.mem_addr, mem_a.mem_wdata});
            end
            if (q_a.size() != 0) begin
                exp_w = q_a.pop_front();
                chk("wr_a", 64'({mem_a.mem_addr, mem_a.mem_wdata}), 64'(exp_w));
            end
        end
        if (resetn === 1'b1 && mem_b.mem_we === 1'b1) begin
            n_vec++;
            assert (q_b.size() != 0)
            else begin
                n_err++;
                $error("FAIL wr_b_unexpected observed=%0h expected=no write",
                       {mem_b.mem_addr, mem_b.mem_wdata});
            end
            if (q_b.size() != 0) begin
                exp_w = q_b.pop_front();
                chk("wr_b", 64'({8'b0, mem_b.mem_addr, mem_b.mem_wdata}), 64'(exp_w));
            end
        end
    endtask

    // One clock: check write port at negedge, return #1 after the posedge.
    task automatic cyc();
        @(negedge clk);
        check_writes();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Advance the timer one step per cycle until play_a[idx]==val; returns
    // the timer value the DUT saw on the edge that changed it, or -1.
    task automatic wait_key(input int idx, input logic val, input int budget, output int t);
        bit found;
        found = 1'b0;
        t = -1;
        for (int i = 0; i < budget && !found; i++) begin
            cyc();
            if (play_a[idx] === val) begin
                found = 1'b1;
                t = int'(timer);
            end else begin
                timer = timer + 1'b1;
            end
        end
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_play"},  64'(play_a), 64'd0);
        chk({tag, "_cnt"},   64'(cnt_a),  64'd0);
        chk({tag, "_ovf"},   64'(ovf_a),  64'd0);
        chk({tag, "_done"},  64'(done_a), 64'd0);
        chk({tag, "_we"},    64'(mem_a.mem_we),    64'd0);
        chk({tag, "_addr"},  64'(mem_a.mem_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(mem_a.mem_wdata), 64'd0);
    endtask

    int t_obs;

    initial begin
        resetn = 1'b0;
        timer  = '0;
        keys   = '0;
        rec_a = 1'b0; pb_a = 1'b0; rst_a = 1'b0;
        rec_b = 1'b0; pb_b = 1'b0; rst_b = 1'b0;
        cycles(3);
        resetn = 1'b1;
        check_reset_a("reset");
        chk("reset_cnt_b", 64'(cnt_b), 64'd0);
        chk("reset_ovf_b", 64'(ovf_b), 64'd0);

        // Two simultaneous presses become two consecutive writes.
        rec_a = 1'b1; timer = 20'd100;
        cyc();
        keys = 32'h5;
        q_a.push_back(wr(0, 100, 0, 1'b1));
        q_a.push_back(wr(1, 100, 2, 1'b1));
        cycles(4);
        chk("rec_basic_cnt", 64'(cnt_a), 64'd2);

        // A key already held when recording starts is logged at that time.
        rec_a = 1'b0;
        cyc();
        keys = 32'h80; timer = 20'd0;
        cyc();
        rec_a = 1'b1;
        q_a.push_back(wr(0, 0, 7, 1'b1));
        cycles(3);
        timer = 20'd5; keys = '0;
        q_a.push_back(wr(1, 5, 7, 1'b0));
        cycles(3);
        chk("held_key_cnt", 64'(cnt_a), 64'd2);

        // Both modes high: recording wins.
        rec_a = 1'b0;
        cyc();
        timer = '0;
        rec_a = 1'b1; pb_a = 1'b1;
        cyc();
        timer = 20'd10; keys = 32'h8;
        q_a.push_back(wr(0, 10, 3, 1'b1));
        cycles(2);
        timer = 20'd20; keys = '0;
        q_a.push_back(wr(1, 20, 3, 1'b0));
        cycles(2);
        chk("prio_cnt", 64'(cnt_a), 64'd2);
        chk("prio_play", 64'(play_a), 64'd0);

        // Playback against a running timer.
        rec_a = 1'b0; timer = '0;
        wait_key(3, 1'b1, 40, t_obs);
        chk("pb_rise_time", 64'(t_obs), 64'(10));
        chk("pb_rise_keys", 64'(play_a), 64'h8);
        wait_key(3, 1'b0, 40, t_obs);
        chk("pb_fall_time", 64'(t_obs), 64'(20));
        for (int i = 0; i < 10 && done_a !== 1'b1; i++) cyc();
        chk("pb_done", 64'(done_a), 64'd1);
        chk("pb_done_keys", 64'(play_a), 64'd0);

        // Three events, restart after the first has been applied.
        pb_a = 1'b0;
        cyc();
        chk("idle_keys", 64'(play_a), 64'd0);
        rec_a = 1'b1; timer = '0; keys = '0;
        cyc();
        timer = 20'd10; keys = 32'h2;
        q_a.push_back(wr(0, 10, 1, 1'b1));
        cycles(2);
        timer = 20'd20; keys = 32'h6;
        q_a.push_back(wr(1, 20, 2, 1'b1));
        cycles(2);
        timer = 20'd30; keys = 32'h4;
        q_a.push_back(wr(2, 30, 1, 1'b0));
        cycles(2);
        chk("rs_cnt", 64'(cnt_a), 64'd3);
        rec_a = 1'b0; pb_a = 1'b1; timer = '0;
        wait_key(1, 1'b1, 40, t_obs);
        chk("rs_first_time", 64'(t_obs), 64'(10));
        for (int i = 0; i < 5; i++) begin
            cyc();
            timer = timer + 1'b1;
        end
        chk("rs_before_keys", 64'(play_a), 64'h2);
        rst_a = 1'b1; timer = '0;
        cyc();
        rst_a = 1'b0;
        chk("rs_cleared_keys", 64'(play_a), 64'd0);
        wait_key(1, 1'b1, 40, t_obs);
        chk("rs_replay_time", 64'(t_obs), 64'(10));
        chk("rs_replay_keys", 64'(play_a), 64'h2);

        // Reset while waiting in APPLY for the 20-tick event.
        for (int i = 0; i < 3; i++) begin
            cyc();
            timer = timer + 1'b1;
        end
        resetn = 1'b0;
        cyc();
        check_reset_a("mid_reset");
        resetn = 1'b1; pb_a = 1'b0; keys = '0;
        cycles(2);

        // Four-entry RAM, five presses.
        timer = 20'd50; rec_b = 1'b1;
        cyc();
        keys = 32'h1F;
        for (int k = 0; k < 4; k++) q_b.push_back(wr(k, 50, k, 1'b1));
        cycles(8);
        chk("ovf_cnt", 64'(cnt_b), 64'd4);
        chk("ovf_flag", 64'(ovf_b), 64'd1);
        rec_b = 1'b0;
        cycles(2);

        chk("q_a_drained", 64'(q_a.size()), 64'd0);
        chk("q_b_drained", 64'(q_b.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
